// File: rtl/ecc_read_checker.sv
// ecc_read_checker
// Read-path ECC check stage. Each 64-bit read word arrives with the 8-bit
// group-parity ECC that was stored beside it. The ECC is recomputed over the
// returned data and XORed with the stored value to form a syndrome. Data is
// never corrected: it is forwarded unmodified with an error flag and the
// syndrome through a two-stage valid/ready pipeline. Errored words leaving
// the pipeline bump a saturating counter, raise a sticky interrupt, and the
// first one since the last clear has its address and syndrome captured.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data, in_ecc     read data and its stored ECC
//   in_addr             address tag travelling with the word
//   out_valid/out_ready output handshake
//   out_data            data, unmodified
//   out_err             syndrome is non-zero
//   out_syndrome        recomputed ECC XOR stored ECC
//   out_addr            address tag
//   clr_stats           one-cycle pulse clearing counter, irq and capture
//   err_count           saturating count of errored words transferred out
//   err_irq             sticky error interrupt
//   first_err_addr/syn  address and syndrome of the first error since clear
module ecc_read_checker #(
    parameter int ADDR_W = 28,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    input  logic [7:0]        in_ecc,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic              out_err,
    output logic [7:0]        out_syndrome,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_irq,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [7:0]        first_err_syn
);

    // Group-parity ECC: seven 7-bit groups, with the top bit also folding in
    // the other seven check bits so that it covers the remaining 15 data bits
    // plus the whole lower check byte.
    function automatic logic [7:0] calc_ecc(input logic [63:0] d);
        logic [7:0] c;
        c[0] = ^d[6:0];
        c[1] = ^d[13:7];
        c[2] = ^d[20:14];
        c[3] = ^d[27:21];
        c[4] = ^d[34:28];
        c[5] = ^d[41:35];
        c[6] = ^d[48:42];
        c[7] = (^d[63:49]) ^ (^c[6:0]);
        return c;
    endfunction

    // Stage 1 holds the raw word, stage 2 the checked word.
    logic              s1_valid_r;
    logic [63:0]       s1_data_r;
    logic [7:0]        s1_ecc_r;
    logic [ADDR_W-1:0] s1_addr_r;

    logic              s2_valid_r;
    logic [63:0]       s2_data_r;
    logic [7:0]        s2_syn_r;
    logic              s2_err_r;
    logic [ADDR_W-1:0] s2_addr_r;

    logic              s2_adv_s;
    logic              s1_adv_s;
    logic [7:0]        s1_syn_s;
    logic              s1_err_s;
    logic              err_xfer_s;

    logic [CNT_W-1:0]  err_count_r;
    logic              err_irq_r;
    logic [ADDR_W-1:0] first_err_addr_r;
    logic [7:0]        first_err_syn_r;

    // Ready chain: a stage may load when it is empty or its successor moves,
    // so a single out_ready pulse opens a slot at the input in the same cycle.
    always_comb begin
        s2_adv_s = !s2_valid_r || out_ready;
        s1_adv_s = !s1_valid_r || s2_adv_s;
        in_ready = s1_adv_s;
    end

    // Syndrome check on the stage-1 word, and detection of an errored word
    // leaving the pipeline (the only event that touches the statistics).
    always_comb begin
        s1_syn_s   = calc_ecc(s1_data_r) ^ s1_ecc_r;
        s1_err_s   = (s1_syn_s != 8'h00);
        err_xfer_s = s2_valid_r && out_ready && s2_err_r;
    end

    // Stage 1 register: payload loads only on an actual input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= 64'h0;
            s1_ecc_r   <= 8'h00;
            s1_addr_r  <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r <= in_data;
                s1_ecc_r  <= in_ecc;
                s1_addr_r <= in_addr;
            end
        end
    end

    // Stage 2 register: drives the out_* ports and holds them while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= 64'h0;
            s2_syn_r   <= 8'h00;
            s2_err_r   <= 1'b0;
            s2_addr_r  <= '0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= s1_data_r;
                s2_syn_r  <= s1_syn_s;
                s2_err_r  <= s1_err_s;
                s2_addr_r <= s1_addr_r;
            end
        end
    end

    // Error statistics. A clear coinciding with an errored transfer behaves
    // as "clear first, then record": the word becomes the new first error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r      <= '0;
            err_irq_r        <= 1'b0;
            first_err_addr_r <= '0;
            first_err_syn_r  <= 8'h00;
        end else if (clr_stats) begin
            if (err_xfer_s) begin
                err_count_r      <= CNT_W'(1);
                err_irq_r        <= 1'b1;
                first_err_addr_r <= s2_addr_r;
                first_err_syn_r  <= s2_syn_r;
            end else begin
                err_count_r      <= '0;
                err_irq_r        <= 1'b0;
                first_err_addr_r <= '0;
                first_err_syn_r  <= 8'h00;
            end
        end else if (err_xfer_s) begin
            if (err_count_r != {CNT_W{1'b1}}) begin
                err_count_r <= err_count_r + CNT_W'(1);
            end
            if (!err_irq_r) begin
                err_irq_r        <= 1'b1;
                first_err_addr_r <= s2_addr_r;
                first_err_syn_r  <= s2_syn_r;
            end
        end
    end

    assign out_valid      = s2_valid_r;
    assign out_data       = s2_data_r;
    assign out_err        = s2_err_r;
    assign out_syndrome   = s2_syn_r;
    assign out_addr       = s2_addr_r;
    assign err_count      = err_count_r;
    assign err_irq        = err_irq_r;
    assign first_err_addr = first_err_addr_r;
    assign first_err_syn  = first_err_syn_r;

endmodule

// File: tb/tb_ecc_read_checker.sv
// Directed testbench for ecc_read_checker. Two instances share the stimulus:
// one with default parameters and one with a 4-bit counter for saturation.
module tb_ecc_read_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ecc;
    logic [27:0] in_addr;
    logic        out_ready;
    logic        clr_stats;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_err;
    logic [7:0]  out_syndrome;
    logic [27:0] out_addr;
    logic [15:0] err_count;
    logic        err_irq;
    logic [27:0] first_err_addr;
    logic [7:0]  first_err_syn;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [63:0] out_data_b;
    logic        out_err_b;
    logic [7:0]  out_syndrome_b;
    logic [27:0] out_addr_b;
    logic [3:0]  err_count_b;
    logic        err_irq_b;
    logic [27:0] first_err_addr_b;
    logic [7:0]  first_err_syn_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecc_read_checker dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ecc(in_ecc), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .out_syndrome(out_syndrome), .out_addr(out_addr),
        .clr_stats(clr_stats), .err_count(err_count), .err_irq(err_irq),
        .first_err_addr(first_err_addr), .first_err_syn(first_err_syn)
    );

    ecc_read_checker #(.ADDR_W(28), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_ecc(in_ecc), .in_addr(in_addr),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_err(out_err_b),
        .out_syndrome(out_syndrome_b), .out_addr(out_addr_b),
        .clr_stats(clr_stats), .err_count(err_count_b), .err_irq(err_irq_b),
        .first_err_addr(first_err_addr_b), .first_err_syn(first_err_syn_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] d, input logic [7:0] e, input logic [27:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_ecc   = e;
        in_addr  = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 64'h0; in_ecc = 8'h00;
        in_addr = 28'd0; out_ready = 1'b1; clr_stats = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if ({out_data, out_err, out_syndrome, out_addr} !== 101'd0) begin failures++; $display("FAIL reset_out_payload data=%h err=%0b syn=%h addr=%h exp=0", out_data, out_err, out_syndrome, out_addr); end
        checks++; if ({err_count, err_irq, first_err_addr, first_err_syn} !== 53'd0) begin failures++; $display("FAIL reset_stats cnt=%0d irq=%0b addr=%h syn=%h exp=0", err_count, err_irq, first_err_addr, first_err_syn); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clean_word();
        offer(64'h0, 8'h00, 28'd1);
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL clean_in_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clean_latency1 got=%0b exp=0", out_valid); end
        step();
        checks++; if ({out_valid, out_err, out_syndrome, out_addr} !== {1'b1, 1'b0, 8'h00, 28'd1}) begin failures++; $display("FAIL clean_out got v=%0b e=%0b syn=%h addr=%h exp v=1 e=0 syn=00 addr=1", out_valid, out_err, out_syndrome, out_addr); end
        step();
        checks++; if ({out_valid, err_count, err_irq} !== {1'b0, 16'd0, 1'b0}) begin failures++; $display("FAIL clean_after got v=%0b cnt=%0d irq=%0b exp 0/0/0", out_valid, err_count, err_irq); end
    endtask

    task automatic test_single_error();
        offer(64'h1, 8'h00, 28'd3);
        step();
        in_valid = 1'b0;
        step();
        checks++; if ({out_valid, out_err, out_syndrome, out_data} !== {1'b1, 1'b1, 8'h81, 64'h1}) begin failures++; $display("FAIL single_out got v=%0b e=%0b syn=%h data=%h exp 1/1/81/1", out_valid, out_err, out_syndrome, out_data); end
        step();
        checks++; if ({err_count, err_irq, first_err_addr, first_err_syn} !== {16'd1, 1'b1, 28'd3, 8'h81}) begin failures++; $display("FAIL single_stats got cnt=%0d irq=%0b addr=%h syn=%h exp 1/1/3/81", err_count, err_irq, first_err_addr, first_err_syn); end
    endtask

    task automatic test_clear();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        checks++; if ({err_count, err_irq, first_err_addr, first_err_syn} !== 53'd0) begin failures++; $display("FAIL clear_stats got cnt=%0d irq=%0b addr=%h syn=%h exp 0", err_count, err_irq, first_err_addr, first_err_syn); end
    endtask

    task automatic test_back_to_back();
        offer(64'h8000_0000_0000_0000, 8'h00, 28'd5);
        step();
        offer(64'h1, 8'h00, 28'd9);
        step();
        in_valid = 1'b0;
        checks++; if ({out_addr, out_syndrome, out_data} !== {28'd5, 8'h80, 64'h8000_0000_0000_0000}) begin failures++; $display("FAIL b2b_first got addr=%h syn=%h data=%h exp 5/80/8000000000000000", out_addr, out_syndrome, out_data); end
        step();
        checks++; if ({out_valid, out_addr, out_syndrome, err_count} !== {1'b1, 28'd9, 8'h81, 16'd1}) begin failures++; $display("FAIL b2b_second got v=%0b addr=%h syn=%h cnt=%0d exp 1/9/81/1", out_valid, out_addr, out_syndrome, err_count); end
        step();
        checks++; if ({out_valid, err_count, err_irq, first_err_addr, first_err_syn} !== {1'b0, 16'd2, 1'b1, 28'd5, 8'h80}) begin failures++; $display("FAIL b2b_capture got v=%0b cnt=%0d irq=%0b addr=%h syn=%h exp 0/2/1/5/80", out_valid, err_count, err_irq, first_err_addr, first_err_syn); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(64'hFF, 8'h03, 28'd20);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_empty_ready got=%0b exp=1", in_ready); end
        step();
        offer(64'h1, 8'h81, 28'd21);
        step();
        offer(64'h0, 8'h01, 28'd22);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
        step();
        checks++; if ({out_valid, out_addr, out_data, out_err} !== {1'b1, 28'd20, 64'hFF, 1'b0}) begin failures++; $display("FAIL bp_stall1 got v=%0b addr=%h data=%h e=%0b exp 1/14/ff/0", out_valid, out_addr, out_data, out_err); end
        step();
        checks++; if ({out_valid, out_addr, out_data, in_ready} !== {1'b1, 28'd20, 64'hFF, 1'b0}) begin failures++; $display("FAIL bp_stall2 got v=%0b addr=%h data=%h rdy=%0b exp 1/14/ff/0", out_valid, out_addr, out_data, in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_pulse_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_addr, out_data, out_err} !== {1'b1, 28'd21, 64'h1, 1'b0}) begin failures++; $display("FAIL bp_drain1 got v=%0b addr=%h data=%h e=%0b exp 1/15/1/0", out_valid, out_addr, out_data, out_err); end
        step();
        checks++; if ({out_valid, out_addr, out_err, out_syndrome} !== {1'b1, 28'd22, 1'b1, 8'h01}) begin failures++; $display("FAIL bp_drain2 got v=%0b addr=%h e=%0b syn=%h exp 1/16/1/01", out_valid, out_addr, out_err, out_syndrome); end
        step();
        checks++; if ({out_valid, err_count, first_err_addr} !== {1'b0, 16'd3, 28'd5}) begin failures++; $display("FAIL bp_done got v=%0b cnt=%0d faddr=%h exp 0/3/5", out_valid, err_count, first_err_addr); end
    endtask

    task automatic test_saturation();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        for (int i = 0; i < 17; i++) begin
            offer(64'h1, 8'h00, 28'd100 + 28'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        checks++; if (err_count_b !== 4'd15) begin failures++; $display("FAIL sat_count4 got=%0d exp=15", err_count_b); end
        checks++; if ({err_count, first_err_addr_b} !== {16'd17, 28'd100}) begin failures++; $display("FAIL sat_count16 got cnt=%0d faddr4=%0d exp 17/100", err_count, first_err_addr_b); end
        offer(64'h8000_0000_0000_0000, 8'h00, 28'h55);
        step();
        in_valid = 1'b0;
        step();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        checks++; if ({err_count_b, err_irq_b, first_err_addr_b, first_err_syn_b} !== {4'd1, 1'b1, 28'h55, 8'h80}) begin failures++; $display("FAIL clr_with_err4 got cnt=%0d irq=%0b addr=%h syn=%h exp 1/1/55/80", err_count_b, err_irq_b, first_err_addr_b, first_err_syn_b); end
        checks++; if ({err_count, first_err_addr} !== {16'd1, 28'h55}) begin failures++; $display("FAIL clr_with_err16 got cnt=%0d addr=%h exp 1/55", err_count, first_err_addr); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        offer(64'hA, 8'h00, 28'h30);
        step();
        offer(64'hB, 8'h00, 28'h31);
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b10) begin failures++; $display("FAIL mid_full got v=%0b rdy=%0b exp 1/0", out_valid, in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL mid_reset_hs got v=%0b rdy=%0b exp 0/1", out_valid, in_ready); end
        checks++; if ({err_count, err_irq, first_err_addr, first_err_syn} !== 53'd0) begin failures++; $display("FAIL mid_reset_stats got cnt=%0d irq=%0b addr=%h syn=%h exp 0", err_count, err_irq, first_err_addr, first_err_syn); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        checks++; if ({out_valid, err_count} !== {1'b0, 16'd0}) begin failures++; $display("FAIL mid_flushed got v=%0b cnt=%0d exp 0/0", out_valid, err_count); end
    endtask

    initial begin
        test_reset();
        test_clean_word();
        test_single_error();
        test_clear();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
